// File: rtl/inv_sbox_calc_if.sv
// Byte handshake bundle for inv_sbox_calc: valid/ready request carrying din,
// valid/ready response carrying dout.
interface inv_sbox_calc_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dout;

    modport master (
        output in_valid,
        output din,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  dout
    );

    modport slave (
        input  in_valid,
        input  din,
        input  out_ready,
        output in_ready,
        output out_valid,
        output dout
    );
endinterface

// File: rtl/inv_sbox_calc.sv
// AES inverse S-box computed algebraically: inverse affine on the input byte,
// then GF(2^8) inversion as b^254 by eight MSB-first square-and-multiply steps.
module inv_sbox_calc (
    input  logic           clk,
    input  logic           rst,
    inv_sbox_calc_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] EXPONENT = 8'hFE;

    state_t     state_q, state_d;
    logic [7:0] b_q, b_d;
    logic [7:0] r_q, r_d;
    logic [2:0] cnt_q, cnt_d;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
        logic [15:0] dbl;
        dbl = {v, v} << n;
        return dbl[15:8];
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] v);
        return rotl8(v, 1) ^ rotl8(v, 3) ^ rotl8(v, 6) ^ 8'h05;
    endfunction

    // Shift-and-add multiply, reducing by 0x11B each time the multiplicand overflows.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    b_d     = inv_affine(bus.din);
                    r_d     = 8'h01;
                    cnt_d   = 3'd7;
                    state_d = EXP;
                end
            end
            EXP: begin
                r_d   = gf_mul(gf_mul(r_q, r_q), EXPONENT[cnt_q] ? b_q : 8'h01);
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.dout      = r_q;
    end

endmodule

// File: doc/inv_sbox_calc.md
# inv_sbox_calc

Multi-cycle AES inverse S-box (InvSubBytes byte engine) computed algebraically rather than from a ROM table. It maps one byte per transaction: inverse affine transform, then the multiplicative inverse in GF(2^8) modulo 0x11B by square-and-multiply (x^254). It sits on the decrypt datapath as the counterpart of the forward `sbox` ROM, and uses valid/ready handshakes on input and output.

## Interface
- Parameters: none.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `din` holds a byte to transform.
- `in_ready`  out  1  block can accept a byte (IDLE only).
- `din`  in  8  input byte (forward S-box output domain).
- `out_valid`  out  1  `dout` holds a finished result.
- `out_ready`  in  1  consumer accepts `dout`.
- `dout`  out  8  InvSbox(din); registered.

## Operation
- Registers: state (IDLE, EXP, DONE), `b[7:0]` operand, `r[7:0]` accumulator, `cnt[2:0]`.
- Inverse affine (combinational on `din`): b = rotl(din,1) ^ rotl(din,3) ^ rotl(din,6) ^ 0x05 (8-bit rotates).
- GF multiply: polynomial product reduced modulo x^8+x^4+x^3+x+1 (0x11B); fully combinational, 8-bit result.
- Exponent E = 254 = 8'b1111_1110, processed MSB first.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: b <= invaffine(din), r <= 0x01, cnt <= 7, go EXP.
- EXP: each cycle r <= gfmul(gfmul(r,r), E[cnt] ? b : 0x01); cnt <= cnt-1. Step with cnt==0 (the eighth step) also sets state to DONE. No early exit.
- Zero input to inversion is not special-cased: 0^254 = 0 naturally (InvSbox(0x63)=0x00).
- DONE: `out_valid`=1, `dout`=r, held stable while `out_ready`=0. On `out_ready`: go IDLE.
- `in_valid` is ignored outside IDLE; `din` is sampled only on the accept edge.
- `out_ready` is ignored outside DONE.

## Timing
- Reset: state IDLE, `in_ready`=1, `out_valid`=0, `dout`=0x00, r=0x00, b=0x00, cnt=0.
- Reset mid-operation (EXP or DONE): abort, return to the reset values on the next edge; the pending result is discarded and never presented.
- Latency: accept at edge E0; EXP steps on E1..E8; `out_valid` high in the cycle after E8.
- Throughput: with `out_ready` tied high, one byte per 10 cycles (accept, 8 EXP, DONE; IDLE re-entered on E9, next accept on E10 at earliest). No overlap between transactions.
- Backpressure: DONE holds indefinitely; `dout` and `out_valid` are stable until the handshake edge.
- `in_ready` and `out_valid` are never high simultaneously.
- `in_ready` and `out_valid` are decoded from the registered state only, with no combinational path from `in_valid`/`out_ready`.

## Test plan
- Reset then `din`=0x63, `out_ready`=1 -> `out_valid` rises exactly 9 cycles after the accept cycle, `dout`=0x00; `in_ready` returns high one cycle after the output handshake.
- Directed values: 0x7C -> 0x01, 0x00 -> 0x52, 0xED -> 0x53, 0xFF -> 0x7D, 0x16 -> 0xFF.
- Exhaustive: for all x in 0..255, feed the forward `sbox` output for x, then check `dout`==x. Run with random `in_valid` gaps; the bench sees 256 results in order.
- Backpressure: hold `out_ready`=0 for 20 cycles in DONE -> `dout` stable and `out_valid` stays 1; `in_ready` stays 0; `in_valid` pulses with other data are ignored; the result is unchanged when finally accepted.
- Reset mid-EXP (4 cycles after accept) -> next cycle all outputs at reset values, no `out_valid`. The next transaction (0x7C) yields 0x01 with the normal latency.
- `rst` asserted in the same cycle as `in_valid` -> no accept. `out_valid` stays 0 for 12 cycles.
